gpio_port_ctrl: RTL and testbench

//   GPIO port controller: register/pin stage directly downstream of the GPIO AXI4-Lite slave interface.

---
 rtl/gpio_pkg.sv | 28 ++
 rtl/gpio_in_filter.sv | 60 ++++++
 rtl/gpio_port_ctrl.sv | 136 +++++++++++++
 tb/tb_gpio_port_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants and helpers for the GPIO port controller.
//   Register word addresses, the address type and a byte-strobe to bit-mask helper.
package gpio_pkg;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned STRB_W = BUS_W / 8;

  typedef logic [2:0] gpio_addr_t;

  localparam gpio_addr_t ADDR_OUT      = 3'd0;
  localparam gpio_addr_t ADDR_DIR      = 3'd1;
  localparam gpio_addr_t ADDR_IN       = 3'd2;
  localparam gpio_addr_t ADDR_IEN      = 3'd3;
  localparam gpio_addr_t ADDR_IEDGE    = 3'd4;
  localparam gpio_addr_t ADDR_IPEND    = 3'd5;
  localparam gpio_addr_t ADDR_DEBOUNCE = 3'd6;

  // Expand byte enables into a per-bit write mask.
  function automatic logic [BUS_W-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
    logic [BUS_W-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: pad input conditioning.
//   2-FF synchroniser per pin, debounce sample prescaler, stable/stable_d registers, edge detect.
// Ports:
//   ACLK, ARESET   clock, async active-high reset
//   i_pins         raw asynchronous pad inputs
//   i_debounce     sample period minus one (0 = sample every cycle)
//   i_restart      restart the prescaler at 0 (DEBOUNCE written)
//   i_iedge        per-pin edge polarity (1 = rising, 0 = falling)
//   o_stable       debounced pin levels
//   o_edge         one-cycle edge indication per pin (combinational from registers)
module gpio_in_filter #(
  parameter int unsigned GPIO_W = 32,
  parameter int unsigned DEB_W  = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [GPIO_W-1:0] i_pins,
  input  logic [DEB_W-1:0]  i_debounce,
  input  logic              i_restart,
  input  logic [GPIO_W-1:0] i_iedge,
  output logic [GPIO_W-1:0] o_stable,
  output logic [GPIO_W-1:0] o_edge
);

  logic [GPIO_W-1:0] r_sync1;
  logic [GPIO_W-1:0] r_sync2;
  logic [GPIO_W-1:0] r_stable;
  logic [GPIO_W-1:0] r_stable_d;
  logic [DEB_W-1:0]  r_presc;

  logic              w_tick;
  logic [DEB_W-1:0]  w_presc_nxt;

  // Sample tick: every cycle when debounce is off, else once per DEBOUNCE+1 cycles.
  assign w_tick      = (i_debounce == '0) || (r_presc == i_debounce);
  assign w_presc_nxt = (i_restart || w_tick) ? '0 : r_presc + DEB_W'(1);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_presc    <= '0;
    end else begin
      r_sync1    <= i_pins;
      r_sync2    <= r_sync1;
      if (w_tick) begin
        r_stable <= r_sync2;
      end
      r_stable_d <= r_stable;
      r_presc    <= w_presc_nxt;
    end
  end

  // Polarity only selects which transition counts, so changing IEDGE alone cannot fire an edge.
  assign o_edge   = (i_iedge & r_stable & ~r_stable_d) | (~i_iedge & ~r_stable & r_stable_d);
  assign o_stable = r_stable;

endmodule

// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl: GPIO register file and pin stage behind the AXI4-Lite slave.
//   Owns OUT/DIR/IEN/IEDGE/IPEND/DEBOUNCE, a registered read port and a level interrupt.
// Ports:
//   ACLK, ARESET                    clock, async active-high reset
//   reg_wr_en/addr/data/strb        one-cycle byte-strobed register write
//   reg_rd_en/addr                  one-cycle register read request
//   reg_rd_data/reg_rd_valid        read data and valid, one cycle after the request
//   gpio_i                          asynchronous pad inputs
//   gpio_o/gpio_oe                  pad output data and output enable (1 = drive)
//   irq                             level interrupt, |(IPEND & IEN) registered
module gpio_port_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned GPIO_W = 32,
  parameter int unsigned DEB_W  = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              reg_wr_en,
  input  logic [2:0]        reg_wr_addr,
  input  logic [31:0]       reg_wr_data,
  input  logic [3:0]        reg_wr_strb,
  input  logic              reg_rd_en,
  input  logic [2:0]        reg_rd_addr,
  output logic [31:0]       reg_rd_data,
  output logic              reg_rd_valid,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  logic [GPIO_W-1:0] r_out;
  logic [GPIO_W-1:0] r_dir;
  logic [GPIO_W-1:0] r_ien;
  logic [GPIO_W-1:0] r_iedge;
  logic [GPIO_W-1:0] r_ipend;
  logic [DEB_W-1:0]  r_deb;
  logic              r_irq;
  logic [BUS_W-1:0]  r_rd_data;
  logic              r_rd_valid;

  logic [BUS_W-1:0]  w_bmask;
  logic [GPIO_W-1:0] w_pmask;
  logic [GPIO_W-1:0] w_pdata;
  logic [DEB_W-1:0]  w_dmask;
  logic [DEB_W-1:0]  w_ddata;
  logic              w_wr_out;
  logic              w_wr_dir;
  logic              w_wr_ien;
  logic              w_wr_iedge;
  logic              w_wr_ipend;
  logic              w_wr_deb;
  logic [GPIO_W-1:0] w_ipend_clr;
  logic [GPIO_W-1:0] w_stable;
  logic [GPIO_W-1:0] w_edge;
  logic [BUS_W-1:0]  w_rd_mux;

  // Write decode; bits above GPIO_W / DEB_W are simply dropped.
  assign w_bmask     = strb_to_mask(reg_wr_strb);
  assign w_pmask     = w_bmask[GPIO_W-1:0];
  assign w_pdata     = reg_wr_data[GPIO_W-1:0];
  assign w_dmask     = w_bmask[DEB_W-1:0];
  assign w_ddata     = reg_wr_data[DEB_W-1:0];
  assign w_wr_out    = reg_wr_en && (reg_wr_addr == ADDR_OUT);
  assign w_wr_dir    = reg_wr_en && (reg_wr_addr == ADDR_DIR);
  assign w_wr_ien    = reg_wr_en && (reg_wr_addr == ADDR_IEN);
  assign w_wr_iedge  = reg_wr_en && (reg_wr_addr == ADDR_IEDGE);
  assign w_wr_ipend  = reg_wr_en && (reg_wr_addr == ADDR_IPEND);
  assign w_wr_deb    = reg_wr_en && (reg_wr_addr == ADDR_DEBOUNCE);
  assign w_ipend_clr = w_wr_ipend ? (w_pdata & w_pmask) : '0;

  gpio_in_filter #(
    .GPIO_W (GPIO_W),
    .DEB_W  (DEB_W)
  ) u_in_filter (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .i_pins     (gpio_i),
    .i_debounce (r_deb),
    .i_restart  (w_wr_deb),
    .i_iedge    (r_iedge),
    .o_stable   (w_stable),
    .o_edge     (w_edge)
  );

  // Read mux sees pre-write register values, so a same-cycle read/write returns the old value.
  always_comb begin
    w_rd_mux = '0;
    case (reg_rd_addr)
      ADDR_OUT:      w_rd_mux = BUS_W'(r_out);
      ADDR_DIR:      w_rd_mux = BUS_W'(r_dir);
      ADDR_IN:       w_rd_mux = BUS_W'(w_stable);
      ADDR_IEN:      w_rd_mux = BUS_W'(r_ien);
      ADDR_IEDGE:    w_rd_mux = BUS_W'(r_iedge);
      ADDR_IPEND:    w_rd_mux = BUS_W'(r_ipend);
      ADDR_DEBOUNCE: w_rd_mux = BUS_W'(r_deb);
      default:       w_rd_mux = '0;
    endcase
  end

  // Register file, pending latch, interrupt and read port.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_out      <= '0;
      r_dir      <= '0;
      r_ien      <= '0;
      r_iedge    <= '0;
      r_ipend    <= '0;
      r_deb      <= '0;
      r_irq      <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_out)   r_out   <= (r_out   & ~w_pmask) | (w_pdata & w_pmask);
      if (w_wr_dir)   r_dir   <= (r_dir   & ~w_pmask) | (w_pdata & w_pmask);
      if (w_wr_ien)   r_ien   <= (r_ien   & ~w_pmask) | (w_pdata & w_pmask);
      if (w_wr_iedge) r_iedge <= (r_iedge & ~w_pmask) | (w_pdata & w_pmask);
      if (w_wr_deb)   r_deb   <= (r_deb   & ~w_dmask) | (w_ddata & w_dmask);
      // A new edge wins over a coincident W1C clear.
      r_ipend    <= (r_ipend & ~w_ipend_clr) | w_edge;
      r_irq      <= |(r_ipend & r_ien);
      r_rd_valid <= reg_rd_en;
      if (reg_rd_en) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  assign gpio_o       = r_out;
  assign gpio_oe      = r_dir;
  assign irq          = r_irq;
  assign reg_rd_data  = r_rd_data;
  assign reg_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// tb_gpio_port_ctrl: directed self-checking bench for gpio_port_ctrl.
//   Inputs are driven on the falling clock edge, outputs sampled on the falling edge.
module tb_gpio_port_ctrl;

  logic        ACLK;
  logic        ARESET;
  logic        reg_wr_en;
  logic [2:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_rd_en;
  logic [2:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic        reg_rd_valid;
  logic [31:0] gpio_i;
  logic [31:0] gpio_o;
  logic [31:0] gpio_oe;
  logic        irq;

  int n_checks;
  int n_fail;

  gpio_port_ctrl #(
    .GPIO_W (32),
    .DEB_W  (16)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .reg_wr_en    (reg_wr_en),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_strb  (reg_wr_strb),
    .reg_rd_en    (reg_rd_en),
    .reg_rd_addr  (reg_rd_addr),
    .reg_rd_data  (reg_rd_data),
    .reg_rd_valid (reg_rd_valid),
    .gpio_i       (gpio_i),
    .gpio_o       (gpio_o),
    .gpio_oe      (gpio_oe),
    .irq          (irq)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge ACLK);
    reg_wr_en   = 1'b1;
    reg_wr_addr = a;
    reg_wr_data = d;
    reg_wr_strb = s;
    @(negedge ACLK);
    reg_wr_en   = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    @(negedge ACLK);
    reg_rd_en   = 1'b1;
    reg_rd_addr = a;
    @(negedge ACLK);
    reg_rd_en   = 1'b0;
    d = reg_rd_data;
    v = reg_rd_valid;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        v;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    n_checks++;
    if (gpio_oe !== 32'h0 || gpio_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pins: got oe=%h o=%h expected 0/0", gpio_oe, gpio_o);
    end
    n_checks++;
    if (irq !== 1'b0 || reg_rd_valid !== 1'b0 || reg_rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outs: got irq=%b valid=%b data=%h expected 0", irq, reg_rd_valid, reg_rd_data);
    end
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d, v);
      n_checks++;
      if (d !== 32'h0 || v !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: got data=%h valid=%b expected 0/1", a, d, v);
      end
      @(negedge ACLK);
      n_checks++;
      if (reg_rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_valid_drop[%0d]: got %b expected 0", a, reg_rd_valid);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic        v;
    bus_write(3'd1, 32'h0000_00FF, 4'hF);
    n_checks++;
    if (gpio_oe !== 32'h0000_00FF) begin
      n_fail++;
      $display("FAIL dir_oe: got %h expected %h", gpio_oe, 32'h0000_00FF);
    end
    bus_write(3'd0, 32'h0000_00A5, 4'hF);
    n_checks++;
    if (gpio_o !== 32'h0000_00A5) begin
      n_fail++;
      $display("FAIL out_o: got %h expected %h", gpio_o, 32'h0000_00A5);
    end
    bus_write(3'd0, 32'hFFFF_FFFF, 4'b0001);
    bus_read(3'd0, d, v);
    n_checks++;
    if (d !== 32'h0000_00FF || gpio_o !== 32'h0000_00FF) begin
      n_fail++;
      $display("FAIL out_strb0: got rd=%h o=%h expected %h", d, gpio_o, 32'h0000_00FF);
    end
    bus_write(3'd0, 32'hAB00_1200, 4'b0010);
    n_checks++;
    if (gpio_o !== 32'h0000_12FF) begin
      n_fail++;
      $display("FAIL out_strb1: got %h expected %h", gpio_o, 32'h0000_12FF);
    end
    bus_write(3'd7, 32'hFFFF_FFFF, 4'hF);
    bus_read(3'd7, d, v);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL reserved_rd: got %h expected 0", d);
    end
    bus_write(3'd2, 32'hFFFF_FFFF, 4'hF);
    bus_read(3'd2, d, v);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL in_ro: got %h expected 0", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        v;
    @(negedge ACLK);
    reg_wr_en   = 1'b1;
    reg_wr_addr = 3'd0;
    reg_wr_data = 32'h0000_0055;
    reg_wr_strb = 4'hF;
    reg_rd_en   = 1'b1;
    reg_rd_addr = 3'd0;
    @(negedge ACLK);
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
    n_checks++;
    if (reg_rd_data !== 32'h0000_12FF || gpio_o !== 32'h0000_0055) begin
      n_fail++;
      $display("FAIL rw_collide: got rd=%h o=%h expected 000012ff/00000055", reg_rd_data, gpio_o);
    end
    bus_read(3'd0, d, v);
    n_checks++;
    if (d !== 32'h0000_0055) begin
      n_fail++;
      $display("FAIL rw_after: got %h expected %h", d, 32'h0000_0055);
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    logic        v;
    logic [4:0]  in_seen;
    logic [4:0]  irq_seen;
    logic [4:0]  exp_in;
    logic [4:0]  exp_irq;
    exp_in  = 5'b11000;
    exp_irq = 5'b10000;
    bus_write(3'd6, 32'h0, 4'hF);
    bus_write(3'd3, 32'h1, 4'hF);
    bus_write(3'd4, 32'h1, 4'hF);
    @(negedge ACLK);
    gpio_i[0]   = 1'b1;
    reg_rd_en   = 1'b1;
    reg_rd_addr = 3'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      in_seen[c]  = reg_rd_data[0];
      irq_seen[c] = irq;
    end
    reg_rd_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (in_seen[c] !== exp_in[c]) begin
        n_fail++;
        $display("FAIL in_latency[%0d]: got %b expected %b", c, in_seen[c], exp_in[c]);
      end
      n_checks++;
      if (irq_seen[c] !== exp_irq[c]) begin
        n_fail++;
        $display("FAIL irq_latency[%0d]: got %b expected %b", c, irq_seen[c], exp_irq[c]);
      end
    end
    bus_read(3'd5, d, v);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL ipend_rise: got %h expected 1", d);
    end
    bus_write(3'd5, 32'h1, 4'hF);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_clr_hold: got %b expected 1", irq);
    end
    @(negedge ACLK);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clr: got %b expected 0", irq);
    end
  endtask

  task automatic test_falling_ien();
    logic [31:0] d;
    logic        v;
    bus_write(3'd4, 32'h1, 4'hF);
    bus_write(3'd3, 32'h0, 4'hF);
    gpio_i[3] = 1'b1;
    repeat (5) @(negedge ACLK);
    bus_read(3'd5, d, v);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL ipend_no_rise3: got %h expected 0", d);
    end
    gpio_i[3] = 1'b0;
    repeat (5) @(negedge ACLK);
    bus_read(3'd5, d, v);
    n_checks++;
    if (d !== 32'h8 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL ipend_fall3: got ipend=%h irq=%b expected 8/0", d, irq);
    end
    bus_write(3'd3, 32'h8, 4'hF);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL ien_set_early: got %b expected 0", irq);
    end
    @(negedge ACLK);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL ien_set_irq: got %b expected 1", irq);
    end
    bus_write(3'd3, 32'h0, 4'hF);
    @(negedge ACLK);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL ien_clr_irq: got %b expected 0", irq);
    end
    bus_read(3'd5, d, v);
    n_checks++;
    if (d !== 32'h8) begin
      n_fail++;
      $display("FAIL ien_clr_keep: got %h expected 8", d);
    end
    bus_write(3'd3, 32'h8, 4'hF);
    repeat (2) @(negedge ACLK);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL ien_reset_irq: got %b expected 1", irq);
    end
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    logic        v;
    int          first_in;
    bus_write(3'd4, 32'h3, 4'hF);
    bus_write(3'd6, 32'hFFFF_FFFF, 4'hF);
    bus_read(3'd6, d, v);
    n_checks++;
    if (d !== 32'h0000_FFFF) begin
      n_fail++;
      $display("FAIL deb_width: got %h expected %h", d, 32'h0000_FFFF);
    end
    bus_write(3'd6, 32'd9, 4'hF);
    first_in  = -1;
    reg_rd_en = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      gpio_i[1]   = ((t >= 2 && t <= 4) || t >= 12);
      reg_rd_addr = (t <= 15) ? 3'd5 : 3'd2;
      @(negedge ACLK);
      if (t == 15) begin
        n_checks++;
        if (reg_rd_data !== 32'h8) begin
          n_fail++;
          $display("FAIL deb_glitch_ipend: got %h expected 8", reg_rd_data);
        end
      end
      if (t >= 16 && first_in < 0 && reg_rd_data[1] === 1'b1) first_in = t;
    end
    reg_rd_en = 1'b0;
    n_checks++;
    if (first_in != 21) begin
      n_fail++;
      $display("FAIL deb_in_update: got cycle %0d expected 21", first_in);
    end
    bus_read(3'd5, d, v);
    n_checks++;
    if (d !== 32'hA) begin
      n_fail++;
      $display("FAIL deb_ipend_hold: got %h expected a", d);
    end
    bus_read(3'd2, d, v);
    n_checks++;
    if (d !== 32'h3) begin
      n_fail++;
      $display("FAIL deb_in_final: got %h expected 3", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        v;
    logic        irq_seen;
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_irq: got %b expected 1", irq);
    end
    @(negedge ACLK);
    #2;
    ARESET = 1'b1;
    #1;
    n_checks++;
    if (gpio_o !== 32'h0 || gpio_oe !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_pins: got o=%h oe=%h irq=%b expected 0", gpio_o, gpio_oe, irq);
    end
    n_checks++;
    if (reg_rd_data !== 32'h0 || reg_rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_rd: got data=%h valid=%b expected 0/0", reg_rd_data, reg_rd_valid);
    end
    gpio_i = 32'h0;
    repeat (2) @(negedge ACLK);
    ARESET   = 1'b0;
    irq_seen = 1'b0;
    repeat (12) begin
      @(negedge ACLK);
      if (irq !== 1'b0) irq_seen = 1'b1;
    end
    n_checks++;
    if (irq_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_irq: got %b expected 0", irq_seen);
    end
    bus_read(3'd5, d, v);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset_ipend: got %h expected 0", d);
    end
    bus_write(3'd4, 32'h1, 4'hF);
    bus_write(3'd3, 32'h1, 4'hF);
    gpio_i[0] = 1'b1;
    repeat (5) @(negedge ACLK);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_new_edge: got %b expected 1", irq);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    ARESET      = 1'b1;
    reg_wr_en   = 1'b0;
    reg_wr_addr = 3'd0;
    reg_wr_data = 32'h0;
    reg_wr_strb = 4'h0;
    reg_rd_en   = 1'b0;
    reg_rd_addr = 3'd0;
    gpio_i      = 32'h0;
    test_reset();
    test_regs();
    test_back_to_back();
    test_edge_irq();
    test_falling_ien();
    test_debounce();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
